// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

  // Loader control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD    = 4;
  localparam int LANE_IDX_W        = $clog2(BYTES_PER_WORD);
  localparam int DEFAULT_ADDR_W    = 5;
  localparam int DEFAULT_MAX_WORDS = 32;

  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - packs little-endian stream bytes into 32-bit words
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  take,
  input  logic [7:0]            data,
  input  logic                  last,
  output logic [31:0]           word_next,
  output logic [LANE_IDX_W-1:0] byte_idx,
  output logic                  word_full
);

  logic [31:0] lanes;

  // Word as it looks once the current byte lands; lane 0 starts a fresh word so upper lanes read zero
  always_comb begin
    word_next = lanes;
    if (byte_idx == '0) begin
      word_next = '0;
    end
    word_next[{byte_idx, 3'b000} +: 8] = data;
    word_full = take && ((byte_idx == LAST_LANE) || last);
  end

  // Lane storage and lane pointer; pointer wraps after a full or terminated word
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lanes    <= '0;
      byte_idx <= '0;
    end else if (take) begin
      lanes    <= word_next;
      byte_idx <= word_full ? '0 : byte_idx + LANE_IDX_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for instruction memory (option: IMEM_LOADER_CHECKSUM_EN)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              core_stall,
  output logic              err_align,
  output logic              err_overflow,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

  state_t                state;
  logic                  word_last;
  logic                  take;
  logic                  restart;
  logic [31:0]           word_next;
  logic [LANE_IDX_W-1:0] byte_idx;
  logic                  word_full;

  assign take    = in_valid && in_ready;
  assign restart = start && ((state == IDLE) || (state == DONE));

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (restart),
    .take      (take),
    .data      (in_data),
    .last      (in_last),
    .word_next (word_next),
    .byte_idx  (byte_idx),
    .word_full (word_full)
  );

  // Loader FSM; every output is registered so it changes together with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      word_count   <= '0;
      done         <= 1'b0;
      core_stall   <= 1'b1;
      err_align    <= 1'b0;
      err_overflow <= 1'b0;
      word_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (word_full) begin
            state     <= WRITE;
            in_ready  <= 1'b0;
            word_last <= in_last;
            if (in_last && (byte_idx != LAST_LANE)) begin
              err_align <= 1'b1;
            end
            if (word_count < MAX_CNT) begin
              wr_en   <= 1'b1;
              wr_addr <= word_count[ADDR_W-1:0];
              wr_data <= word_next;
            end else begin
              err_overflow <= 1'b1;
            end
          end
        end
        WRITE: begin
          wr_en <= 1'b0;
          if (wr_en) begin
            word_count <= word_count + (ADDR_W + 1)'(1);
          end
          if (word_last) begin
            state      <= DONE;
            done       <= 1'b1;
            core_stall <= 1'b0;
          end else begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state        <= LOAD;
            in_ready     <= 1'b1;
            done         <= 1'b0;
            core_stall   <= 1'b1;
            word_count   <= '0;
            err_align    <= 1'b0;
            err_overflow <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Running XOR of committed words, advancing on the same edge as word_count
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      checksum_q <= '0;
    end else if ((state == WRITE) && wr_en) begin
      checksum_q <= checksum_q ^ wr_data;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader (default and MAX_WORDS=2 instances)
module tb_imem_loader;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [5:0]  count;
    logic        align;
    logic        ovf;
    logic [31:0] cks;
  } dn_t;

  logic clk;
  logic rst;
  logic start;
  logic in_valid;
  logic [7:0] in_data;
  logic in_last;

  logic        a_in_ready, a_wr_en, a_done, a_core_stall, a_err_align, a_err_overflow;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data, a_checksum;
  logic [5:0]  a_word_count;

  logic        b_in_ready, b_wr_en, b_done, b_core_stall, b_err_align, b_err_overflow;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data, b_checksum;
  logic [5:0]  b_word_count;

  wr_t wq_a[$];
  wr_t wq_b[$];
  dn_t dq_a[$];
  dn_t dq_b[$];
  logic [7:0] stim[$];

  int n_cmp = 0;
  int n_bad = 0;
  int hs_b  = 0;
  logic done_a_q = 1'b0;
  logic done_b_q = 1'b0;

  imem_loader dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(a_in_ready), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .word_count(a_word_count), .done(a_done), .core_stall(a_core_stall),
    .err_align(a_err_align), .err_overflow(a_err_overflow), .checksum(a_checksum)
  );

  imem_loader #(.ADDR_W(5), .MAX_WORDS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(b_in_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .word_count(b_word_count), .done(b_done), .core_stall(b_core_stall),
    .err_align(b_err_align), .err_overflow(b_err_overflow), .checksum(b_checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ck(input logic [31:0] v);
`ifdef IMEM_LOADER_CHECKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not expected or bound expired", name);
  endtask

  // Monitor: pops expected writes and load results as the DUTs present them
  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (a_wr_en) begin
      if (wq_a.size() == 0) fail_now("a_unexpected_write");
      else begin
        w = wq_a.pop_front();
        check("a_wr_addr", 32'(a_wr_addr), 32'(w.addr));
        check("a_wr_data", a_wr_data, w.data);
        check("a_ready_in_write", 32'(a_in_ready), 32'h0);
      end
    end
    if (b_wr_en) begin
      if (wq_b.size() == 0) fail_now("b_unexpected_write");
      else begin
        w = wq_b.pop_front();
        check("b_wr_addr", 32'(b_wr_addr), 32'(w.addr));
        check("b_wr_data", b_wr_data, w.data);
        check("b_ready_in_write", 32'(b_in_ready), 32'h0);
      end
    end
    if (a_done && !done_a_q) begin
      if (dq_a.size() == 0) fail_now("a_unexpected_done");
      else begin
        d = dq_a.pop_front();
        check("a_word_count", 32'(a_word_count), 32'(d.count));
        check("a_err_align", 32'(a_err_align), 32'(d.align));
        check("a_err_overflow", 32'(a_err_overflow), 32'(d.ovf));
        check("a_checksum", a_checksum, d.cks);
        check("a_core_stall", 32'(a_core_stall), 32'h0);
      end
    end
    if (b_done && !done_b_q) begin
      if (dq_b.size() == 0) fail_now("b_unexpected_done");
      else begin
        d = dq_b.pop_front();
        check("b_word_count", 32'(b_word_count), 32'(d.count));
        check("b_err_align", 32'(b_err_align), 32'(d.align));
        check("b_err_overflow", 32'(b_err_overflow), 32'(d.ovf));
        check("b_checksum", b_checksum, d.cks);
        check("b_core_stall", 32'(b_core_stall), 32'h0);
      end
    end
    if (in_valid && b_in_ready) hs_b <= hs_b + 1;
    done_a_q <= a_done;
    done_b_q <= b_done;
  end

  task automatic push_wr(input logic [4:0] addr, input logic [31:0] data, input bit to_b);
    wr_t w;
    w.addr = addr;
    w.data = data;
    wq_a.push_back(w);
    if (to_b) wq_b.push_back(w);
  endtask

  task automatic push_dn(input bit is_b, input logic [5:0] cnt, input logic al, input logic ov, input logic [31:0] cks);
    dn_t d;
    d.count = cnt;
    d.align = al;
    d.ovf   = ov;
    d.cks   = cks;
    if (is_b) dq_b.push_back(d);
    else dq_a.push_back(d);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("in_ready_after_start", 32'(a_in_ready), 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last, input bit gap);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (a_in_ready) break;
      t++;
      if (t > 20) begin
        fail_now("send_timeout");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_all(input bit gap);
    for (int i = 0; i < stim.size(); i++) send(stim[i], (i == stim.size() - 1), gap);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!(a_done && b_done)) begin
      @(negedge clk);
      t++;
      if (t > 30) begin
        fail_now("done_timeout");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_case1();
    push_wr(5'd0, 32'h00000013, 1'b1);
    push_wr(5'd1, 32'h002100B3, 1'b1);
    push_dn(1'b0, 6'd2, 1'b0, 1'b0, ck(32'h002100A0));
    push_dn(1'b1, 6'd2, 1'b0, 1'b0, ck(32'h002100A0));
  endtask

  initial begin
    int hs0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(a_in_ready), 32'h0);
    check("rst_wr_en", 32'(a_wr_en), 32'h0);
    check("rst_wr_addr", 32'(a_wr_addr), 32'h0);
    check("rst_wr_data", a_wr_data, 32'h0);
    check("rst_word_count", 32'(a_word_count), 32'h0);
    check("rst_done", 32'(a_done), 32'h0);
    check("rst_core_stall", 32'(a_core_stall), 32'h1);
    check("rst_err_align", 32'(a_err_align), 32'h0);
    check("rst_err_overflow", 32'(a_err_overflow), 32'h0);
    check("rst_checksum", a_checksum, 32'h0);
    @(posedge clk); #1;

    // Case 1: two aligned words back to back
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h21, 8'h00};
    expect_case1();
    do_start();
    send_all(1'b0);
    wait_done();

    // Case 2: in_last mid-word, restarted from DONE
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00};
    push_wr(5'd0, 32'h00000013, 1'b1);
    push_wr(5'd1, 32'h000000B3, 1'b1);
    push_dn(1'b0, 6'd2, 1'b1, 1'b0, ck(32'h000000A0));
    push_dn(1'b1, 6'd2, 1'b1, 1'b0, ck(32'h000000A0));
    do_start();
    send_all(1'b0);
    wait_done();

    // Case 3: same stream as case 1 with in_valid toggling
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h21, 8'h00};
    expect_case1();
    do_start();
    send_all(1'b1);
    wait_done();

    // Case 4: reset after three bytes, then a clean reload
    do_start();
    send(8'h13, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(a_in_ready), 32'h0);
    check("midrst_core_stall", 32'(a_core_stall), 32'h1);
    check("midrst_done", 32'(a_done), 32'h0);
    check("midrst_word_count", 32'(a_word_count), 32'h0);
    check("midrst_wr_en", 32'(a_wr_en), 32'h0);
    @(posedge clk); #1;
    expect_case1();
    do_start();
    send_all(1'b0);
    wait_done();

    // Case 5: three words; the MAX_WORDS=2 instance drops the third
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    push_wr(5'd0, 32'h44332211, 1'b1);
    push_wr(5'd1, 32'h88776655, 1'b1);
    push_wr(5'd2, 32'hCCBBAA99, 1'b0);
    push_dn(1'b0, 6'd3, 1'b0, 1'b0, ck(32'h00FFEEDD));
    push_dn(1'b1, 6'd2, 1'b0, 1'b1, ck(32'hCC444444));
    hs0 = hs_b;
    do_start();
    send_all(1'b0);
    wait_done();
    check("b_handshakes", 32'(hs_b - hs0), 32'd12);

    repeat (3) @(posedge clk);
    check("wq_a_left", 32'(wq_a.size()), 32'h0);
    check("wq_b_left", 32'(wq_b.size()), 32'h0);
    check("dq_a_left", 32'(dq_a.size()), 32'h0);
    check("dq_b_left", 32'(dq_b.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
